// File: rtl/spi_boot_loader_pkg.sv
// Shared definitions for the SPI boot loader: FSM encoding, SRAM address width
// and the default boot image window.
package spi_boot_loader_pkg;

  localparam int SRAM_ADDR_W = 18;

  localparam logic [SRAM_ADDR_W-1:0] DEF_BOOT_START_ADDR = 18'h0C000;
  localparam logic [SRAM_ADDR_W-1:0] DEF_BOOT_END_ADDR   = 18'h0FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } boot_state_t;

endpackage

// File: rtl/spi_boot_loader_rx_shifter.sv
// SPI receive front end: synchronises the ARM SPI pins into clk, detects edges,
// and assembles MSB-first bytes, emitting a one-cycle byte_vld per complete byte.
module spi_rx_shifter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       arm_ss,
  input  logic       arm_sclk,
  input  logic       arm_mosi,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       ss_act
);

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   ss_d;
  logic                   sclk_d;
  logic                   ss_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_q;

  // Select and clock idle high, so their synchronisers reset high to avoid a
  // false edge when reset is released.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_d      <= 1'b1;
      sclk_d    <= 1'b1;
    end else begin
      ss_sync   <= (ss_sync << 1) | SYNC_STAGES'(arm_ss);
      sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(arm_sclk);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(arm_mosi);
      ss_d      <= ss_s;
      sclk_d    <= sclk_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_act    = ~ss_s;

  // Counter is held clear whenever select is inactive, which also drops any
  // partial byte when select rises mid-byte.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bit_cnt  <= 3'd0;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      if (ss_fall || !ss_act) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ss_act && sclk_rise) begin
      shift_q <= {shift_q[5:0], mosi_s};
      if (bit_cnt == 3'd7) begin
        byte_data <= {shift_q, mosi_s};
      end
    end
  end

endmodule

// File: rtl/spi_boot_loader.sv
// Boot loader: receives a boot image over SPI from the ARM and writes it byte by
// byte into SRAM, holding the CPU in reset (booting) until the load finishes.
// Optional running checksum of written bytes is enabled by SPI_BOOT_CHECKSUM_EN.
module spi_boot_loader
  import spi_boot_loader_pkg::*;
#(
  parameter logic [SRAM_ADDR_W-1:0] BOOT_START_ADDR = DEF_BOOT_START_ADDR,
  parameter logic [SRAM_ADDR_W-1:0] BOOT_END_ADDR   = DEF_BOOT_END_ADDR,
  parameter int                     SYNC_STAGES     = 2
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   arm_ss,
  input  logic                   arm_sclk,
  input  logic                   arm_mosi,
  output logic                   wr_req,
  input  logic                   wr_ack,
  output logic [SRAM_ADDR_W-1:0] wr_addr,
  output logic [7:0]             wr_data,
  output logic                   booting,
  output logic                   overrun,
  output logic [7:0]             checksum
);

  boot_state_t state;
  boot_state_t next_state;
  logic        byte_vld;
  logic [7:0]  byte_data;
  logic        ss_fall;
  logic        ss_rise;
  logic        ss_act;
  logic        ack_take;
  logic        at_end;
  logic        acked_any;
  logic        accept_byte;
  logic        drop_byte;

  spi_rx_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .reset_b   (reset_b),
    .arm_ss    (arm_ss),
    .arm_sclk  (arm_sclk),
    .arm_mosi  (arm_mosi),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .ss_act    (ss_act)
  );

  assign ack_take    = wr_req & wr_ack;
  assign at_end      = (wr_addr == BOOT_END_ADDR);
  assign accept_byte = (state == RECV) & byte_vld;
  assign drop_byte   = (state == WRITE) & byte_vld;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A pending write always finishes before the select level decides whether
  // the load has ended; once any byte is acked, select rising ends the load.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          next_state = RECV;
        end
      end
      RECV: begin
        if (byte_vld) begin
          next_state = WRITE;
        end else if (ss_rise) begin
          next_state = acked_any ? DONE : IDLE;
        end
      end
      WRITE: begin
        if (ack_take) begin
          next_state = (at_end || !ss_act) ? DONE : RECV;
        end
      end
      DONE: begin
        next_state = DONE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_req    <= 1'b0;
      wr_addr   <= BOOT_START_ADDR;
      wr_data   <= 8'h00;
      overrun   <= 1'b0;
      acked_any <= 1'b0;
    end else begin
      if (accept_byte) begin
        wr_req  <= 1'b1;
        wr_data <= byte_data;
      end else if (ack_take) begin
        wr_req    <= 1'b0;
        acked_any <= 1'b1;
        if (!at_end) begin
          wr_addr <= wr_addr + SRAM_ADDR_W'(1);
        end
      end
      if (drop_byte) begin
        overrun <= 1'b1;
      end
    end
  end

  assign booting = (state != DONE);

`ifdef SPI_BOOT_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      checksum_q <= 8'h00;
    end else if (ack_take) begin
      checksum_q <= checksum_q + wr_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: doc/spi_boot_loader.md
SPI_BOOT_LOADER -- requirements
Module: spi_boot_loader

Interface
REQ-001 Parameters SHALL be: BOOT_START_ADDR, 'h0C000, first SRAM address written; BOOT_END_ADDR, 'h0FFFF, last SRAM address written; SYNC_STAGES, 2, input synchroniser depth.
REQ-002 Ports SHALL be, one per line:
  clk  in  1  system clock, sole clock domain
  reset_b  in  1  asynchronous active-low reset
  arm_ss  in  1  SPI select from ARM, active low, asynchronous to clk
  arm_sclk  in  1  SPI clock from ARM, idle high; data sampled on rising edge
  arm_mosi  in  1  SPI data from ARM, MSB first
  wr_req  out  1  SRAM write request, held until acked
  wr_ack  in  1  one-cycle SRAM write completion from arbiter
  wr_addr  out  18  SRAM write address
  wr_data  out  8  SRAM write data
  booting  out  1  high while boot image load is in progress; holds CPU in reset
  overrun  out  1  sticky: byte lost due to unacked previous write
  checksum  out  8  modulo-256 sum of written bytes (macro-dependent)

Function
REQ-003 arm_ss, arm_sclk, arm_mosi SHALL pass through SYNC_STAGES flops before use; clk SHALL be at least 4x arm_sclk.
REQ-004 A bit SHALL be shifted in, MSB first, on each synchronised arm_sclk rising edge while synchronised arm_ss is low.
REQ-005 Bit counter SHALL reset to 0 on arm_ss falling edge; eighth bit SHALL complete a byte into a one-entry holding buffer.
REQ-006 FSM states SHALL be IDLE, RECV, WRITE, DONE.
REQ-007 IDLE->RECV on arm_ss falling edge; RECV->WRITE on byte complete; WRITE->RECV on wr_ack with address < BOOT_END_ADDR; WRITE->DONE on wr_ack with address = BOOT_END_ADDR.
REQ-008 wr_req SHALL assert the cycle after byte complete and remain high with stable wr_addr/wr_data until the cycle wr_ack is sampled high; wr_req SHALL deassert the following cycle.
REQ-009 Address counter SHALL start at BOOT_START_ADDR and increment by 1 per acked write; no write SHALL be issued beyond BOOT_END_ADDR.
REQ-010 Shifting SHALL continue during WRITE; a byte completing while wr_req is still pending SHALL be discarded and SHALL set overrun.
REQ-011 arm_ss rising mid-byte SHALL discard the partial byte; FSM SHALL return to IDLE (or complete a pending write first, then IDLE).
REQ-012 arm_ss rising with at least one byte acked SHALL enter DONE after any pending write completes.
REQ-013 booting SHALL be high in IDLE/RECV/WRITE and low in DONE; DONE SHALL be absorbing until reset; SPI activity in DONE SHALL be ignored.
REQ-014 wr_ack while wr_req low SHALL be ignored.

Reset
REQ-015 On reset_b low, asynchronously: FSM=IDLE, wr_req=0, wr_addr=BOOT_START_ADDR, wr_data=0, booting=1, overrun=0, checksum=0, bit counter and synchronisers cleared (sclk/ss synchronisers to 1).
REQ-016 Reset asserted mid-transfer SHALL abandon the transfer; next arm_ss falling edge restarts at BOOT_START_ADDR.

Configuration
REQ-017 With SPI_BOOT_CHECKSUM_EN defined, checksum SHALL add wr_data modulo 256 on each acked write; without it, checksum SHALL be constant 0 and no adder SHALL be synthesised.

Structure
REQ-018 Shared package SHALL hold the FSM state encoding, default BOOT_START_ADDR/BOOT_END_ADDR, and the 18-bit SRAM address width constant.
REQ-019 One sub-module, spi_rx_shifter (synchroniser, edge detect, bit counter, shift register, byte-valid pulse), SHALL be instantiated; FSM and address counter stay in top level.

Verification
REQ-020 Full image: 16384 bytes at 20 MHz sclk, 100 MHz clk, wr_ack 2 cycles after req -> 16384 writes 'h0C000..'h0FFFF, data matches, booting falls after last ack, overrun=0.
REQ-021 Abort: ss rises after 5 bits of the first byte -> no write, FSM IDLE, booting=1; next full byte writes to 'h0C000.
REQ-022 Backpressure: wr_ack withheld 100 cycles (> one byte time) -> second byte dropped, overrun=1, first byte written correctly.
REQ-023 Early end: 3 bytes 'hA5,'h5A,'hFF then ss rises -> writes 'h0C000..'h0C002, booting=0, further SPI traffic produces no writes.
REQ-024 Reset at byte 100 -> outputs at reset values immediately; restart reloads from 'h0C000.
REQ-025 With SPI_BOOT_CHECKSUM_EN, bytes 'h80,'h90,'h01 -> checksum='h11; without it, checksum=0.
